// File: rtl/prog_mem_loader.sv
// Program/data memory behind the CPU fetch port, filled by a host byte stream.
// Holds the CPU in reset while loading and releases it once the program is in.
module prog_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   ld_count
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        RUN
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic              hs;
    logic              full;
    logic              restart;

    assign hs      = ld_valid & ld_ready;
    assign full    = (ld_count == CW'(DEPTH - 1));
    assign restart = ld_start & ((state == IDLE) | (state == RUN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (ld_start) state_n = LOAD;
            LOAD: if (hs && (ld_last || full)) state_n = DONE;
            DONE: state_n = RUN;
            RUN:  if (ld_start) state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end

    // Flags are registered copies of the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            cpu_rst  <= 1'b0;
        end else begin
            ld_ready <= (state_n == LOAD);
            ld_done  <= (state_n == DONE);
            cpu_rst  <= (state_n == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            ld_count <= '0;
        end else if (restart) begin
            wr_ptr   <= '0;
            ld_count <= '0;
        end else if (hs) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            ld_count <= ld_count + CW'(1);
        end
    end

    // Array is deliberately not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    assign mem_data = (state == RUN) ? mem[mem_addr] : '0;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed loads, scoreboard on ld_done events.
// Level checks sample 1 time unit after the active edge.
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       ld_done;
    logic       cpu_rst;
    logic [6:0] ld_count;

    int total = 0;
    int bad   = 0;
    int exp_q [$];
    logic prev_done = 1'b0;

    prog_mem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .cpu_rst  (cpu_rst),
        .ld_count (ld_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic rd(input string name, input int a, input int exp);
        mem_addr = 6'(a);
        #1;
        check(name, int'(mem_data), exp);
    endtask

    // Monitor: every ld_done pulse must match a queued load and be 1 cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ld_done) begin
                check("done_single", int'(prev_done), 0);
                check("done_cpu_rst", int'(cpu_rst), 0);
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    check("done_count", int'(ld_count), exp_q.pop_front());
                end
            end
            prev_done = ld_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        rst      = 1'b0;
        mem_addr = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        repeat (5) tick();
        check("rst_cpu_rst", int'(cpu_rst), 0);
        check("rst_ready", int'(ld_ready), 0);
        check("rst_done", int'(ld_done), 0);
        check("rst_count", int'(ld_count), 0);
        rd("rst_rd0", 0, 8'h00);
        rd("rst_rd63", 63, 8'h00);

        rst = 1'b1;
        tick();
        check("idle_ready", int'(ld_ready), 0);

        // Basic three-byte load
        start();
        check("basic_ready", int'(ld_ready), 1);
        rd("basic_rd_hidden", 0, 8'h00);
        exp_q.push_back(3);
        send(8'h81, 1'b0);
        send(8'h42, 1'b0);
        send(8'hC0, 1'b1);
        check("basic_done", int'(ld_done), 1);
        check("basic_ready_off", int'(ld_ready), 0);
        check("basic_count", int'(ld_count), 3);
        tick();
        check("basic_cpu_run", int'(cpu_rst), 1);
        check("basic_done_off", int'(ld_done), 0);
        rd("basic_rd0", 0, 8'h81);
        rd("basic_rd1", 1, 8'h42);
        rd("basic_rd2", 2, 8'hC0);

        // Full 64-byte load with auto exit
        start();
        check("full_cpu_hold", int'(cpu_rst), 0);
        rd("full_rd_hidden", 2, 8'h00);
        exp_q.push_back(64);
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        check("full_ready_off", int'(ld_ready), 0);
        check("full_count", int'(ld_count), 64);
        send(8'hAA, 1'b0);
        check("full_65_count", int'(ld_count), 64);
        tick();
        check("full_cpu_run", int'(cpu_rst), 1);
        rd("full_rd0", 0, 8'h00);
        rd("full_rd5", 5, 8'h05);
        rd("full_rd63", 63, 8'h3F);

        // Stalls, with ld_start ignored mid-load
        start();
        exp_q.push_back(2);
        ld_valid = 1'b1; ld_data = 8'h11; tick();
        ld_valid = 1'b0; ld_data = 8'h22; ld_start = 1'b1; tick();
        ld_start = 1'b0; ld_data = 8'h33; tick();
        ld_valid = 1'b1; ld_data = 8'h44; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("stall_count", int'(ld_count), 2);
        tick();
        rd("stall_rd0", 0, 8'h11);
        rd("stall_rd1", 1, 8'h44);
        rd("stall_rd2", 2, 8'h02);

        // Reload from RUN
        start();
        check("reload_cpu_hold", int'(cpu_rst), 0);
        rd("reload_rd_hidden", 1, 8'h00);
        exp_q.push_back(1);
        send(8'h7F, 1'b1);
        tick();
        check("reload_count", int'(ld_count), 1);
        rd("reload_rd0", 0, 8'h7F);
        rd("reload_rd1", 1, 8'h44);

        // ld_last coinciding with the 64th byte
        start();
        exp_q.push_back(64);
        for (int i = 0; i < 64; i++) send(8'(63 - i), 1'(i == 63));
        check("last64_count", int'(ld_count), 64);
        repeat (2) tick();
        rd("last64_rd0", 0, 8'h3F);
        rd("last64_rd63", 63, 8'h00);

        // Reset abort mid-load
        start();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_ready", int'(ld_ready), 0);
        check("abort_cpu_rst", int'(cpu_rst), 0);
        check("abort_count", int'(ld_count), 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("abort_idle_ready", int'(ld_ready), 0);
        start();
        exp_q.push_back(1);
        send(8'h5A, 1'b1);
        tick();
        rd("abort_rd0", 0, 8'h5A);
        rd("abort_rd1", 1, 8'hA2);
        rd("abort_rd2", 2, 8'h3D);

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- 64x8 program/data memory that acts as the responder on the CPU memory port: the CPU drives mem_addr and this block returns mem_data.
- A byte-stream loader port lets a host write a program into the memory.
- While loading, the block holds the CPU in reset; once loading completes, it releases the CPU to run from address 0.
- Sits beside cpu at the top level: cpu.mem_addr drives this block's mem_addr, this block's mem_data drives cpu.mem_data, and this block's cpu_rst drives cpu.rst.

Parameters:
- ADDR_W, 6, address width; matches the CPU AR/PC width.
- DATA_W, 8, data width; matches the CPU bus.
- DEPTH, 64, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_addr  input  ADDR_W  CPU read address.
- mem_data  output  DATA_W  read data returned to the CPU.
- ld_start  input  1  one-cycle request to begin (re)loading from address 0.
- ld_valid  input  1  host has a byte on ld_data.
- ld_data  input  DATA_W  byte to write.
- ld_last  input  1  qualifies the current byte as the final byte; sampled only on a handshake.
- ld_ready  output  1  block accepts a byte this cycle.
- ld_done  output  1  one-cycle pulse when loading ends.
- cpu_rst  output  1  reset to the CPU, active-low: 0 = CPU held in reset, 1 = CPU runs.
- ld_count  output  ADDR_W+1  bytes accepted in the current/last load, range 0..64.

Behaviour:
- State machine has four states: IDLE, LOAD, DONE, RUN.
- Reset (rst=0, asynchronous):
  - state=IDLE, write pointer=0, ld_count=0.
  - ld_ready=0, ld_done=0, cpu_rst=0.
  - Memory array contents are not cleared.
- IDLE:
  - cpu_rst=0, ld_ready=0.
  - ld_start=1 → LOAD next edge; pointer and ld_count cleared to 0.
- LOAD:
  - ld_ready=1 (registered; it is 1 from the first cycle in LOAD).
  - Handshake is ld_valid & ld_ready at a rising edge. On a handshake:
    - mem[pointer] <= ld_data.
    - pointer <= pointer+1.
    - ld_count <= ld_count+1.
  - Exit → DONE when the handshake has ld_last=1, or when it is the 64th byte (ld_count was 63).
  - In both exit cases ld_ready is 0 in the following cycle. No 65th write and no pointer wrap into address 0.
  - ld_start during LOAD is ignored.
  - ld_valid=0 stalls indefinitely; there is no timeout.
- DONE:
  - Lasts exactly one cycle with ld_done=1, cpu_rst=0, ld_ready=0.
  - Unconditionally → RUN.
- RUN:
  - cpu_rst=1 and ld_ready=0; ld_count holds its final value.
  - ld_start=1 → LOAD next edge; pointer and ld_count cleared.
  - cpu_rst is registered low on that same edge, so the CPU is in reset from the first LOAD cycle.
- Read path:
  - mem_data = mem[mem_addr] combinationally (asynchronous read), only in RUN.
  - In IDLE, LOAD and DONE, mem_data=8'h00 so the CPU never sees partial programs.
  - Read latency 0 cycles: the CPU AR updates on the edge and mem_data is valid in the same cycle.
- Outputs are registered except mem_data.
- Reset asserted mid-LOAD:
  - Aborts immediately to IDLE; bytes already written stay in memory.
  - A subsequent ld_start reloads from address 0.
- ld_last on the 64th byte: single exit to DONE, single ld_done pulse.
- ld_done is never asserted for more than 1 cycle and never outside DONE.
- Bytes presented when ld_ready=0 are dropped, with no write and no count change.

Test Plan:
- Reset, then hold 5 cycles: cpu_rst=0, ld_ready=0, ld_done=0, ld_count=0, mem_data=00 for any mem_addr.
- Basic load:
  - Stimulus: ld_start; then bytes 8'h81,8'h42,8'hC0 back-to-back with ld_last on the third.
  - Response: ld_ready=1 from the cycle after ld_start; ld_done pulse 1 cycle after the third handshake; ld_count=3; cpu_rst=1 one cycle later.
  - Readback: mem_addr=0,1,2 → 81,42,C0 with 0-cycle latency.
- Full load:
  - Stimulus: 64 bytes with data=address, no ld_last.
  - Response: auto-exit after byte 64, ld_count=64, ld_ready=0 afterward.
  - A 65th ld_valid byte is ignored, and mem[0] is still 00.
- Stalls:
  - Stimulus: ld_valid toggled 1,0,0,1 with ld_data changing every cycle.
  - Response: only bytes present at ld_valid=1 are written; ld_count is 2 after two handshakes.
- Reload and reset abort:
  - From RUN, pulse ld_start: cpu_rst=0 on the next cycle, mem_data=00, then reload of 1 byte 8'h7F with ld_last → mem[0]=7F.
  - Separately, assert rst=0 mid-LOAD after 2 bytes: immediate IDLE, ld_ready=0, no ld_done pulse.
- Integrated with cpu:
  - Stimulus: load a short program (add/inc/jump loop); then free-run.
  - Response: cpu.ac_out increments per loop iteration, and the CPU resumes from PC=0 after each reload.
